// File: rtl/stack_machine.sv
`default_nettype none
// ============================================================================
// Module   : stack_machine
// Purpose  : Evaluates one RPN expression y = f(x) for a single screen column.
//            Tokens are fetched one at a time from an external output queue
//            and evaluated on an internal fixed-point stack. The result is
//            returned as a fixed-point screen row.
// Revision : 1.0 - initial release
// ============================================================================
module stack_machine #(
    parameter int INTEGER_PART_WIDTH    = 11,
    parameter int FRACTIONAL_PART_WIDTH = 8,
    parameter int OUTPUT_QUEUE_SIZE     = 64,
    parameter int HOR_ACTIVE_PIXELS     = 640,
    parameter int VER_ACTIVE_PIXELS     = 480,
    parameter int STACK_SIZE            = 16,
    localparam int NUMBER_WIDTH         = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH,
    localparam int OUTPUT_VALUE_WIDTH   = NUMBER_WIDTH + 1,
    localparam int IDX_W                = $clog2(OUTPUT_QUEUE_SIZE),
    localparam int LEN_W                = $clog2(OUTPUT_QUEUE_SIZE + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic                          ready,
    input  logic [NUMBER_WIDTH-1:0]       x_input,
    output logic [NUMBER_WIDTH-1:0]       y_output,
    output logic [IDX_W-1:0]              output_queue_index,
    output logic                          output_queue_get,
    input  logic [LEN_W-1:0]              output_queue_length,
    input  logic [OUTPUT_VALUE_WIDTH-1:0] output_queue_data_out,
    input  logic                          output_queue_ready
);

    localparam int N      = NUMBER_WIDTH;
    localparam int F      = FRACTIONAL_PART_WIDTH;
    localparam int SP_W   = $clog2(STACK_SIZE + 1);
    localparam int SPI_W  = $clog2(STACK_SIZE);
    localparam int DCNT_W = $clog2(N + F);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_DIV    = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    localparam logic [N-1:0]    c_OP_ADD      = N'(1);
    localparam logic [N-1:0]    c_OP_SUB      = N'(2);
    localparam logic [N-1:0]    c_OP_MUL      = N'(3);
    localparam logic [N-1:0]    c_OP_DIV      = N'(4);
    localparam logic [N-1:0]    c_OP_NEG      = N'(5);
    localparam logic [N-1:0]    c_OP_PUSHX    = N'(6);
    localparam logic [N-1:0]    c_X_ORIGIN    = N'(HOR_ACTIVE_PIXELS / 2);
    localparam logic [N-1:0]    c_Y_ORIGIN    = N'((VER_ACTIVE_PIXELS / 2) << F);
    localparam logic [N-1:0]    c_MAX_POS     = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]    c_MIN_NEG     = {1'b1, {(N-1){1'b0}}};
    localparam logic [SP_W-1:0] c_STACK_DEPTH = SP_W'(STACK_SIZE);

    logic [2:0]        r_state;
    logic [N-1:0]      r_stack [0:STACK_SIZE-1];
    logic [SP_W-1:0]   r_sp;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_i;
    logic [N-1:0]      r_x;
    logic [N:0]        r_token;
    logic [N-1:0]      r_div_rem;
    logic [N+F-1:0]    r_div_q;
    logic [N-1:0]      r_div_b;
    logic              r_div_neg;
    logic [DCNT_W-1:0] r_div_cnt;

    logic [SP_W-1:0]     w_sp_m1, w_sp_m2, w_sp_pop1, w_sp_pop2;
    logic [N-1:0]        w_a, w_b, w_a_abs, w_b_abs;
    logic                w_is_op, w_is_push, w_is_bin, w_is_neg, w_div_start;
    logic [N-1:0]        w_code, w_push_val, w_bin_res, w_mul, w_x_start, w_y;
    logic signed [2*N-1:0] w_prod;
    logic [N:0]          w_rem_sh;
    logic                w_ge;
    logic [N+F-1:0]      w_q_next;
    logic [N-1:0]        w_rem_next, w_quot_mag, w_quot;
    logic [LEN_W-1:0]    w_i_next;
    logic                w_more;

    // Operand selection with underflow reading as zero, and token decode
    always_comb begin
        w_sp_m1     = r_sp - 1'b1;
        w_sp_m2     = r_sp - 2'd2;
        w_b         = (r_sp >= SP_W'(1)) ? r_stack[SPI_W'(w_sp_m1)] : '0;
        w_a         = (r_sp >= SP_W'(2)) ? r_stack[SPI_W'(w_sp_m2)] : '0;
        w_sp_pop1   = (r_sp >= SP_W'(1)) ? w_sp_m1 : '0;
        w_sp_pop2   = (r_sp >= SP_W'(2)) ? w_sp_m2 : '0;
        w_a_abs     = w_a[N-1] ? -w_a : w_a;
        w_b_abs     = w_b[N-1] ? -w_b : w_b;
        w_is_op     = r_token[N];
        w_code      = r_token[N-1:0];
        w_is_push   = !w_is_op || (w_code == c_OP_PUSHX);
        w_push_val  = w_is_op ? r_x : r_token[N-1:0];
        w_is_bin    = w_is_op && ((w_code == c_OP_ADD) || (w_code == c_OP_SUB) ||
                                  (w_code == c_OP_MUL) || (w_code == c_OP_DIV));
        w_is_neg    = w_is_op && (w_code == c_OP_NEG);
        w_div_start = w_is_op && (w_code == c_OP_DIV) && (w_b != '0);
        w_prod      = $signed(w_a) * $signed(w_b);
        w_mul       = N'(w_prod >>> F);
        w_bin_res   = '0;
        case (w_code)
            c_OP_ADD: w_bin_res = w_a + w_b;
            c_OP_SUB: w_bin_res = w_a - w_b;
            c_OP_MUL: w_bin_res = w_mul;
            c_OP_DIV: w_bin_res = w_a[N-1] ? c_MIN_NEG : c_MAX_POS;
            default:  w_bin_res = '0;
        endcase
        w_x_start   = (x_input - c_X_ORIGIN) << F;
        w_y         = c_Y_ORIGIN - w_b;
        w_i_next    = r_i + 1'b1;
        w_more      = (w_i_next < r_len);
    end

    // One restoring-division step on magnitudes; sign applied on the last step
    always_comb begin
        w_rem_sh   = {r_div_rem, r_div_q[N+F-1]};
        w_ge       = (w_rem_sh >= {1'b0, r_div_b});
        w_q_next   = {r_div_q[N+F-2:0], w_ge};
        w_rem_next = w_ge ? N'(w_rem_sh - {1'b0, r_div_b}) : N'(w_rem_sh);
        w_quot_mag = N'(w_q_next);
        w_quot     = r_div_neg ? -w_quot_mag : w_quot_mag;
    end

    // Control FSM, evaluation stack and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state            <= S_IDLE;
            ready              <= 1'b1;
            y_output           <= '0;
            output_queue_get   <= 1'b0;
            output_queue_index <= '0;
            r_sp               <= '0;
            r_len              <= '0;
            r_i                <= '0;
            r_x                <= '0;
            r_token            <= '0;
            r_div_rem          <= '0;
            r_div_q            <= '0;
            r_div_b            <= '0;
            r_div_neg          <= 1'b0;
            r_div_cnt          <= '0;
        end else begin
            output_queue_get <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len <= output_queue_length;
                        r_sp  <= '0;
                        r_x   <= w_x_start;
                        r_i   <= '0;
                        ready <= 1'b0;
                        if (output_queue_length == '0) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_state            <= S_FETCH;
                            output_queue_get   <= 1'b1;
                            output_queue_index <= '0;
                        end
                    end
                end
                S_FETCH: r_state <= S_WAIT;
                S_WAIT: begin
                    if (output_queue_ready) begin
                        r_token <= output_queue_data_out;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_div_start) begin
                        r_div_q   <= {w_a_abs, {F{1'b0}}};
                        r_div_rem <= '0;
                        r_div_b   <= w_b_abs;
                        r_div_neg <= w_a[N-1] ^ w_b[N-1];
                        r_div_cnt <= DCNT_W'(N + F - 1);
                        r_sp      <= w_sp_pop2;
                        r_state   <= S_DIV;
                    end else begin
                        if (w_is_push) begin
                            // A push onto a full stack is silently dropped
                            if (r_sp < c_STACK_DEPTH) begin
                                r_stack[SPI_W'(r_sp)] <= w_push_val;
                                r_sp                  <= r_sp + 1'b1;
                            end
                        end else if (w_is_bin) begin
                            r_stack[SPI_W'(w_sp_pop2)] <= w_bin_res;
                            r_sp                       <= w_sp_pop2 + 1'b1;
                        end else if (w_is_neg) begin
                            r_stack[SPI_W'(w_sp_pop1)] <= -w_b;
                            r_sp                       <= w_sp_pop1 + 1'b1;
                        end
                        r_i <= w_i_next;
                        if (w_more) begin
                            r_state            <= S_FETCH;
                            output_queue_get   <= 1'b1;
                            output_queue_index <= IDX_W'(w_i_next);
                        end else begin
                            r_state <= S_FINISH;
                        end
                    end
                end
                S_DIV: begin
                    r_div_rem <= w_rem_next;
                    r_div_q   <= w_q_next;
                    r_div_cnt <= r_div_cnt - 1'b1;
                    if (r_div_cnt == '0) begin
                        // Operands were popped on entry, so the push always fits
                        r_stack[SPI_W'(r_sp)] <= w_quot;
                        r_sp                  <= r_sp + 1'b1;
                        r_i                   <= w_i_next;
                        if (w_more) begin
                            r_state            <= S_FETCH;
                            output_queue_get   <= 1'b1;
                            output_queue_index <= IDX_W'(w_i_next);
                        end else begin
                            r_state <= S_FINISH;
                        end
                    end
                end
                S_FINISH: begin
                    y_output <= w_y;
                    ready    <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stack_machine.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_machine
// Purpose  : Self-checking bench for stack_machine against a queue-based
//            arithmetic reference model with a randomized token responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stack_machine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        ready;
    logic [18:0] x_input;
    logic [18:0] y_output;
    logic [5:0]  output_queue_index;
    logic        output_queue_get;
    logic [6:0]  output_queue_length;
    logic [19:0] output_queue_data_out;
    logic        output_queue_ready;

    logic [19:0] tq [0:63];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          tb_next_idx = 0;
    int          dmin = 0;
    int          dmax = 8;
    logic        mute = 1'b0;

    stack_machine dut (
        .clk                   (clk),
        .reset                 (reset),
        .start                 (start),
        .ready                 (ready),
        .x_input               (x_input),
        .y_output              (y_output),
        .output_queue_index    (output_queue_index),
        .output_queue_get      (output_queue_get),
        .output_queue_length   (output_queue_length),
        .output_queue_data_out (output_queue_data_out),
        .output_queue_ready    (output_queue_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic longint wrapn(input longint v);
        longint m;
        m = v & 64'h7FFFF;
        if (m >= 64'h40000) m = m - 64'h80000;
        return m;
    endfunction

    // Reference: evaluate the RPN list with a bounded queue used as a stack
    function automatic logic [18:0] model(input int x, input int len);
        longint st[$];
        longint a, b, xv, y, v;
        logic [19:0] t;
        logic [18:0] val;
        xv = wrapn((longint'(x) - 320) * 256);
        for (int i = 0; i < len; i++) begin
            t   = tq[i];
            val = t[18:0];
            if (!t[19] || val == 19'd6) begin
                v = t[19] ? xv : wrapn(longint'(val));
                if (st.size() < 16) st.push_back(v);
            end else if (val >= 19'd1 && val <= 19'd5) begin
                b = (st.size() > 0) ? st.pop_back() : 0;
                a = 0;
                if (val != 19'd5) a = (st.size() > 0) ? st.pop_back() : 0;
                case (val)
                    19'd1: v = wrapn(a + b);
                    19'd2: v = wrapn(a - b);
                    19'd3: v = wrapn((a * b) >>> 8);
                    19'd4: v = (b == 0) ? ((a >= 0) ? 262143 : -262144) : wrapn((a * 256) / b);
                    default: v = wrapn(-b);
                endcase
                st.push_back(v);
            end
        end
        y = (st.size() > 0) ? st[$] : 0;
        return 19'(wrapn(61440 - y));
    endfunction

    // Queue responder: answers each get after a random latency
    initial begin
        int d;
        int idx;
        output_queue_ready    = 1'b0;
        output_queue_data_out = '0;
        forever begin
            @(posedge clk);
            #1;
            if (output_queue_get) begin
                idx = int'(output_queue_index);
                check("fetch_idx", idx, tb_next_idx);
                tb_next_idx++;
                d = $urandom_range(dmax, dmin);
                @(posedge clk);
                repeat (d) @(posedge clk);
                @(negedge clk);
                if (!mute) begin
                    output_queue_ready    = 1'b1;
                    output_queue_data_out = tq[idx];
                    @(negedge clk);
                    output_queue_ready    = 1'b0;
                    output_queue_data_out = '0;
                end
            end
        end
    end

    task automatic run_eval(input int x, input int len, input int extra, input string tag);
        logic [18:0] exp;
        bit          done;
        exp  = model(x, len);
        done = 1'b0;
        x_input             = 19'(x);
        output_queue_length = 7'(len);
        tb_next_idx         = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({tag, "_busy"}, 32'(ready), 32'd0);
        for (int c = 2; c < 5000; c++) begin
            @(negedge clk);
            if (ready) begin
                done = 1'b1;
                break;
            end
            start = (c == extra);
        end
        start = 1'b0;
        if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
        check({tag, "_y"}, 32'(y_output), 32'(exp));
        check({tag, "_fetches"}, tb_next_idx, len);
        repeat (2) @(negedge clk);
        check({tag, "_hold"}, 32'(y_output), 32'(exp));
    endtask

    function automatic logic [19:0] rand_token();
        int r;
        logic [18:0] lit;
        r = $urandom_range(99, 0);
        if (r < 8) return {1'b0, 19'($urandom)};
        if (r < 38) begin
            lit = 19'(($urandom_range(4095, 0) - 2048) * 16);
            return {1'b0, lit};
        end
        if (r < 90) return {1'b1, 19'($urandom_range(6, 1))};
        return {1'b1, 19'($urandom_range(19'h7FFFF, 7))};
    endfunction

    initial begin
        int len;
        int x;
        reset = 1'b1;
        start = 1'b0;
        x_input = '0;
        output_queue_length = '0;
        for (int i = 0; i < 64; i++) tq[i] = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_get",   32'(output_queue_get), 32'd0);
        check("rst_y",     32'(y_output), 32'd0);
        check("rst_index", 32'(output_queue_index), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // x=300: X + 1.0 with ~100 ns response latency
        dmin = 9; dmax = 10;
        tq[0] = {1'b1, 19'd6}; tq[1] = {1'b0, 19'h100}; tq[2] = {1'b1, 19'd1};
        run_eval(300, 3, 0, "xplus1");
        check("xplus1_const", 32'(y_output), 32'h10300);
        dmin = 0; dmax = 8;

        // x*x at x=322
        tq[0] = {1'b1, 19'd6}; tq[1] = {1'b1, 19'd6}; tq[2] = {1'b1, 19'd3};
        run_eval(322, 3, 0, "xsq");
        check("xsq_const", 32'(y_output), 32'(236 << 8));

        // division by zero saturates
        tq[0] = {1'b0, 19'h500}; tq[1] = {1'b0, 19'h0}; tq[2] = {1'b1, 19'd4};
        run_eval(0, 3, 0, "div0");
        check("div0_const", 32'(y_output), 32'h4F001);

        // signed division through the sequential divider
        tq[0] = {1'b0, 19'h7F900}; tq[1] = {1'b0, 19'h300}; tq[2] = {1'b1, 19'd4};
        run_eval(0, 3, 0, "divneg");

        // empty expression
        run_eval(100, 0, 0, "len0");
        check("len0_const", 32'(y_output), 32'(240 << 8));

        // overflow: 20 pushes, only the first 16 land
        for (int i = 0; i < 20; i++) tq[i] = {1'b0, 19'((i + 1) * 256)};
        run_eval(0, 20, 0, "ovf");
        check("ovf_const", 32'(y_output), 32'(224 << 8));

        // underflow: operators on an empty stack
        tq[0] = {1'b1, 19'd1}; tq[1] = {1'b1, 19'd5}; tq[2] = {1'b1, 19'd2}; tq[3] = {1'b1, 19'd4};
        run_eval(0, 4, 0, "udf");

        // second start while busy is ignored
        tq[0] = {1'b1, 19'd6}; tq[1] = {1'b0, 19'h100}; tq[2] = {1'b1, 19'd1};
        run_eval(300, 3, 4, "dblstart");
        check("dblstart_const", 32'(y_output), 32'h10300);

        // reset while waiting for a token
        mute = 1'b1;
        x_input = 19'd300;
        output_queue_length = 7'd3;
        tb_next_idx = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (6) @(negedge clk);
        check("wait_get", 32'(output_queue_get), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_get",   32'(output_queue_get), 32'd0);
        check("midrst_y",     32'(y_output), 32'd0);
        repeat (14) @(negedge clk);
        mute = 1'b0;
        run_eval(300, 3, 0, "postrst");

        // randomized expressions
        for (int n = 0; n < 40; n++) begin
            len = $urandom_range(24, 0);
            if (n % 10 == 9) len = $urandom_range(64, 40);
            for (int i = 0; i < len; i++) tq[i] = rand_token();
            x = (n % 4 == 3) ? int'($urandom_range(19'h7FFFF, 0)) : int'($urandom_range(639, 0));
            run_eval(x, len, (n % 5 == 0) ? 5 : 0, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
